// File: rtl/sdram_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sdram_defs
// Shared definitions for the SDRAM access controller: FSM state encoding,
// default timing/geometry constants and small width helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_defs;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACT      = 3'd1,
    ST_RCD_WAIT = 3'd2,
    ST_RW       = 3'd3,
    ST_CL_WAIT  = 3'd4,
    ST_PRECHG   = 3'd5,
    ST_RP_WAIT  = 3'd6,
    ST_REFRESH  = 3'd7
  } state_t;

  localparam int DEF_ROW_ADDR_DEPTH   = 8;
  localparam int DEF_COL_ADDR_DEPTH   = 8;
  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_TRCD             = 2;
  localparam int DEF_TCL              = 2;
  localparam int DEF_TRP              = 2;
  localparam int DEF_REFRESH_INTERVAL = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// sdram_access_ctrl_if
// Bundles the request/return handshake and the SDRAM command/data bus.
//   slave  : the controller side (accepts requests, drives RAS/CAS/WE/PRE,
//            addresses, write data and read returns; samples mem_rdata)
//   master : the requester/memory-model side
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake
//   rd_valid/rd_data                              : read return
//   RAS/CAS/WE/PRE/RowAddr/ColAddr/mem_wdata      : SDRAM command/data out
//   mem_rdata                                     : SDRAM read data in
// -----------------------------------------------------------------------------
interface sdram_access_ctrl_if #(
  parameter int ROW_ADDR_DEPTH = 8,
  parameter int COL_ADDR_DEPTH = 8,
  parameter int DATA_WIDTH     = 8
);

  logic                                     req_valid;
  logic                                     req_ready;
  logic                                     req_we;
  logic [ROW_ADDR_DEPTH+COL_ADDR_DEPTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]                    req_wdata;

  logic                                     rd_valid;
  logic [DATA_WIDTH-1:0]                    rd_data;

  logic                                     RAS;
  logic                                     CAS;
  logic                                     WE;
  logic                                     PRE;
  logic [ROW_ADDR_DEPTH-1:0]                RowAddr;
  logic [COL_ADDR_DEPTH-1:0]                ColAddr;
  logic [DATA_WIDTH-1:0]                    mem_wdata;
  logic [DATA_WIDTH-1:0]                    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rd_valid, rd_data,
    output RAS, CAS, WE, PRE, RowAddr, ColAddr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rd_valid, rd_data,
    input  RAS, CAS, WE, PRE, RowAddr, ColAddr, mem_wdata
  );

endinterface

// File: rtl/sdram_access_ctrl_delay_counter.sv
// -----------------------------------------------------------------------------
// sdram_delay_counter
// Loadable down counter shared by the RCD, CL and RP wait states.
// Loading value L keeps o_done low for L cycles; o_done is high in the
// (L+1)-th cycle after the load edge, so a wait of N cycles loads N-1.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (counter -> 0)
//   i_load     : load i_load_val on this edge
//   i_load_val : value to load
//   o_done     : counter has reached zero
// -----------------------------------------------------------------------------
module sdram_delay_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sdram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_access_ctrl
// Closed-page SDRAM access controller: one read or write per activation
// (ACT -> RW -> PRECHG), with periodic auto-refresh issued only from IDLE.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : sdram_access_ctrl_if.slave (request handshake, read return,
//           SDRAM command/address/data)
//   busy  : high whenever the FSM is not in IDLE
// Command outputs (RAS/CAS/WE/PRE) and read return are flops loaded from the
// next-state decode, so each one is high exactly in the cycle its state is.
// -----------------------------------------------------------------------------
module sdram_access_ctrl
  import sdram_defs::*;
#(
  parameter int ROW_ADDR_DEPTH   = DEF_ROW_ADDR_DEPTH,
  parameter int COL_ADDR_DEPTH   = DEF_COL_ADDR_DEPTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int TRCD             = DEF_TRCD,
  parameter int TCL              = DEF_TCL,
  parameter int TRP              = DEF_TRP,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_access_ctrl_if.slave   bus,
  output logic                 busy
);

  localparam int ADDR_W = ROW_ADDR_DEPTH + COL_ADDR_DEPTH;
  localparam int CNT_W  = bits_for(max3(TRCD, TCL, TRP));
  localparam int REF_W  = bits_for(REFRESH_INTERVAL);

  // ACT itself is the first of the TRCD cycles, so RCD_WAIT lasts TRCD-1
  // cycles (skipped entirely when TRCD is 1).
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [CNT_W-1:0] CL_LOAD  = CNT_W'(TCL - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(TRP - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);

  state_t                    r_state;
  state_t                    w_state_next;

  logic                      w_accept;
  logic                      w_ref_issue;
  logic                      w_dly_load;
  logic [CNT_W-1:0]          w_dly_val;
  logic                      w_dly_done;
  logic                      w_rd_sample;

  logic                      r_we_lat;
  logic [ROW_ADDR_DEPTH-1:0] r_row;
  logic [COL_ADDR_DEPTH-1:0] r_col;
  logic [DATA_WIDTH-1:0]     r_wdata;

  logic                      r_ras;
  logic                      r_cas;
  logic                      r_we;
  logic                      r_pre;
  logic                      r_rd_valid;
  logic [DATA_WIDTH-1:0]     r_rd_data;

  logic [REF_W-1:0]          r_ref_cnt;
  logic                      r_ref_pending;

  // Reset is folded in so the requester never sees ready while reset is held.
  assign bus.req_ready = (r_state == ST_IDLE) && !r_ref_pending && !reset;
  assign w_accept      = bus.req_ready && bus.req_valid;
  assign w_ref_issue   = (r_state == ST_IDLE) && r_ref_pending;
  // Last CL_WAIT cycle: this edge captures mem_rdata.
  assign w_rd_sample   = (r_state == ST_CL_WAIT) && w_dly_done;
  assign busy          = (r_state != ST_IDLE);

  sdram_delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_val),
    .o_done     (w_dly_done)
  );

  // ---------------------------------------------------------------------------
  // Next-state / wait-counter load decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_dly_load   = 1'b0;
    w_dly_val    = '0;
    case (r_state)
      ST_IDLE: begin
        // Refresh wins over a simultaneous request.
        if (r_ref_pending) begin
          w_state_next = ST_REFRESH;
        end else if (bus.req_valid) begin
          w_state_next = ST_ACT;
        end
      end
      ST_ACT: begin
        if (TRCD > 1) begin
          w_state_next = ST_RCD_WAIT;
          w_dly_load   = 1'b1;
          w_dly_val    = RCD_LOAD;
        end else begin
          w_state_next = ST_RW;
        end
      end
      ST_RCD_WAIT: begin
        if (w_dly_done) begin
          w_state_next = ST_RW;
        end
      end
      ST_RW: begin
        if (r_we_lat) begin
          w_state_next = ST_PRECHG;
        end else begin
          w_state_next = ST_CL_WAIT;
          w_dly_load   = 1'b1;
          w_dly_val    = CL_LOAD;
        end
      end
      ST_CL_WAIT: begin
        if (w_dly_done) begin
          w_state_next = ST_PRECHG;
        end
      end
      ST_PRECHG, ST_REFRESH: begin
        w_state_next = ST_RP_WAIT;
        w_dly_load   = 1'b1;
        w_dly_val    = RP_LOAD;
      end
      ST_RP_WAIT: begin
        if (w_dly_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and registered command outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ras      <= 1'b0;
      r_cas      <= 1'b0;
      r_we       <= 1'b0;
      r_pre      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      // REF is encoded as RAS and CAS together.
      r_ras      <= (w_state_next == ST_ACT) || (w_state_next == ST_REFRESH);
      r_cas      <= (w_state_next == ST_RW)  || (w_state_next == ST_REFRESH);
      r_we       <= (w_state_next == ST_RW)  && r_we_lat;
      r_pre      <= (w_state_next == ST_PRECHG);
      r_rd_valid <= w_rd_sample;
      if (w_rd_sample) begin
        r_rd_data <= bus.mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch: row/col/data stay on the bus until the next acceptance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we_lat <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we_lat <= bus.req_we;
      r_row    <= bus.req_addr[ADDR_W-1:COL_ADDR_DEPTH];
      r_col    <= bus.req_addr[COL_ADDR_DEPTH-1:0];
      r_wdata  <= bus.req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh interval counter; a new expiry takes precedence over clearing
  // so that an interval ending on the issue edge is not lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + REF_W'(1);
      if (w_ref_issue) begin
        r_ref_pending <= 1'b0;
      end
    end
  end

  assign bus.RAS       = r_ras;
  assign bus.CAS       = r_cas;
  assign bus.WE        = r_we;
  assign bus.PRE       = r_pre;
  assign bus.RowAddr   = r_row;
  assign bus.ColAddr   = r_col;
  assign bus.mem_wdata = r_wdata;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;

endmodule
